// File: rtl/polygon_area.sv
// Shoelace area of one convex polygon from an angle-sorted vertex stream.
// One shared 10x10 multiplier, two cycles per edge, one-cycle result strobe.
module polygon_area #(
  parameter int MAX_PTS = 6,
  parameter int ACC_W   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [9:0]  Xin,
  input  logic [9:0]  Yin,
  input  logic [2:0]  point_num,
  output logic        busy,
  output logic        area_valid,
  output logic [19:0] area
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CALC_A = 3'd2;
  localparam logic [2:0] S_CALC_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] MAXN = 3'(MAX_PTS);

  logic [2:0] state;
  logic [2:0] n;
  logic [2:0] k;
  logic [2:0] i;
  logic [2:0] j;
  logic [2:0] n_in;
  logic [2:0] wr_idx;
  logic       wr_en;

  logic [9:0] xs [MAX_PTS];
  logic [9:0] ys [MAX_PTS];

  logic [9:0]  op_a;
  logic [9:0]  op_b;
  logic [19:0] prod;
  logic [19:0] p;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [ACC_W-1:0] acc_abs;

  assign n_in = (point_num > MAXN) ? MAXN : point_num;
  assign j    = (i == n - 3'd1) ? 3'd0 : i + 3'd1;

  assign busy       = (state != S_IDLE);
  assign area_valid = (state == S_DONE);

  // Vertex write port: slot 0 from IDLE, slot k while loading
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = k;
    if (in_valid && state == S_IDLE) begin
      wr_en  = 1'b1;
      wr_idx = 3'd0;
    end else if (in_valid && state == S_LOAD) begin
      wr_en  = 1'b1;
    end
  end

  // Shared multiplier: x_i*y_j in CALC_A, x_j*y_i in CALC_B
  always_comb begin
    op_a = xs[i];
    op_b = ys[j];
    if (state == S_CALC_B) begin
      op_a = xs[j];
      op_b = ys[i];
    end
    prod = {10'd0, op_a} * {10'd0, op_b};
  end

  // Accumulate one edge term and fold to magnitude for the result
  always_comb begin
    acc_nx = acc
           + $signed({{(ACC_W-20){1'b0}}, p})
           - $signed({{(ACC_W-20){1'b0}}, prod});
    acc_abs = acc_nx[ACC_W-1] ? -acc_nx : acc_nx;
  end

  // Vertex storage, no reset needed: always rewritten before use
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      xs[wr_idx] <= Xin;
      ys[wr_idx] <= Yin;
    end
  end

  // Frame sequencer: capture, per-edge products, result
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      n     <= 3'd0;
      k     <= 3'd0;
      i     <= 3'd0;
      p     <= 20'd0;
      acc   <= '0;
      area  <= 20'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n   <= n_in;
            k   <= 3'd1;
            i   <= 3'd0;
            acc <= '0;
            if (n_in <= 3'd1) begin
              state <= S_DONE;
              area  <= 20'd0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            k <= k + 3'd1;
            if (k == n - 3'd1) begin
              i   <= 3'd0;
              acc <= '0;
              if (n < 3'd3) begin
                state <= S_DONE;
                area  <= 20'd0;
              end else begin
                state <= S_CALC_A;
              end
            end
          end
        end
        S_CALC_A: begin
          p     <= prod;
          state <= S_CALC_B;
        end
        S_CALC_B: begin
          acc <= acc_nx;
          if (i == n - 3'd1) begin
            state <= S_DONE;
            area  <= 20'($unsigned(acc_abs) >> 1);
          end else begin
            i     <= i + 3'd1;
            state <= S_CALC_A;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
